hazard_control_unit: RTL and testbench
======================================

HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 5, register-index width.
REQ-002 SHALL have parameter CNT_W, default 32, performance-counter width.
REQ-003 SHALL have port clk  in  1  clock, all state on rising edge.
REQ-004 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports id_rs1_i, id_rs2_i  in  REG_ADDR_W  source registers of the instruction in ID.
REQ-006 SHALL have ports id_uses_rs1_i, id_uses_rs2_i  in  1  qualify rs1/rs2 as real reads.
REQ-007 SHALL have ports ex_rd_i  in  REG_ADDR_W, ex_mem_read_i  in  1  destination and load flag of the instruction in EX.
REQ-008 SHALL have port ex_mispredict_i  in  1  branch resolved in EX against its prediction.
REQ-009 SHALL have ports ex_mc_start_i, mc_done_i  in  1  multi-cycle op (div) in EX; result ready.
REQ-010 SHALL have ports mem_req_i, dmem_ready_i  in  1  MEM-stage data access pending; memory acknowledge.
REQ-011 SHALL have outputs pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_stall_o, id_ex_flush_o, ex_mem_stall_o, ex_mem_flush_o  out  1  per-register controls.
REQ-012 SHALL have outputs stall_count_o, flush_count_o  out  CNT_W  performance counters.

Function
REQ-013 States SHALL be RUN, MC_WAIT, MEM_WAIT; controls combinational from state and inputs, zero-latency.
REQ-014 Priority, highest first: memory wait > multi-cycle wait > mispredict > load-use.
REQ-015 Memory wait (mem_req_i & !dmem_ready_i, any state): assert pc, if_id, id_ex, ex_mem stalls; no flush; next state MEM_WAIT.
REQ-016 MEM_WAIT: cycle with dmem_ready_i=1 SHALL drop all MEM stalls and return to RUN.
REQ-017 Multi-cycle (RUN, ex_mc_start_i & !mc_done_i): assert pc, if_id, id_ex stalls and ex_mem_flush_o; next MC_WAIT.
REQ-018 MC_WAIT: hold same outputs until mc_done_i=1; that cycle outputs deasserted, return RUN.
REQ-019 ex_mc_start_i & mc_done_i together in RUN SHALL produce no stall.
REQ-020 Mispredict (RUN, no higher event): assert if_id_flush_o and id_ex_flush_o; PC not stalled; one cycle per asserted input cycle.
REQ-021 Load-use: ex_mem_read_i & ex_rd_i!=0 & ((id_uses_rs1_i & id_rs1_i==ex_rd_i) | (id_uses_rs2_i & id_rs2_i==ex_rd_i)); assert pc_stall_o, if_id_stall_o, id_ex_flush_o one cycle.
REQ-022 Load-use suppressed when mispredict asserted same cycle.
REQ-023 Invariant: a register's stall and flush never both 1.
REQ-024 stall_count_o +1 per cycle pc_stall_o=1; flush_count_o +1 per cycle if_id_flush_o=1; both saturate at all-ones.

Reset
REQ-025 reset_n low SHALL force state RUN, counters 0, all control outputs 0, immediately and asynchronously.
REQ-026 Reset mid-MC_WAIT or MEM_WAIT SHALL abandon the wait; after release state is RUN.

Structure
REQ-027 Shared package pipeline_pkg SHALL hold state enum, REG_ADDR_W default and NOP constant 32'h00000013.
REQ-028 Sub-module hazard_perf_counter (saturating CNT_W counter, enable input) SHALL be instantiated twice.

Verification
REQ-029 ex_mem_read=1, ex_rd=5, id_rs2=5, uses_rs2=1 -> one cycle pc_stall=if_id_stall=id_ex_flush=1; stall_count=1.
REQ-030 Same plus ex_rd=0 -> no stall; plus ex_mispredict=1 -> if_id_flush=id_ex_flush=1 only; flush_count=1.
REQ-031 ex_mc_start=1, mc_done at 4th cycle -> 3 cycles stalled with ex_mem_flush=1, released 4th cycle; stall_count=3.
REQ-032 mem_req=1, dmem_ready low 2 cycles during MC_WAIT with mispredict=1 -> full stall, no flushes, then resume MC_WAIT.
REQ-033 reset_n low during MEM_WAIT -> outputs 0 same cycle, counters 0, RUN after release; CNT_W=4, 20 stall cycles -> stall_count=15.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: hazard FSM states, control bundle, default widths.
package pipeline_pkg;

    localparam int          REG_ADDR_W_DEF = 5;
    localparam logic [31:0] NOP            = 32'h00000013;  // addi x0, x0, 0

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MC_WAIT  = 2'd1,
        MEM_WAIT = 2'd2
    } hcu_state_e;

    typedef struct packed {
        logic pc_stall;
        logic if_id_stall;
        logic if_id_flush;
        logic id_ex_stall;
        logic id_ex_flush;
        logic ex_mem_stall;
        logic ex_mem_flush;
    } hcu_ctrl_t;

endpackage

// File: rtl/hazard_perf_counter.sv
// Saturating event counter, increments once per enabled cycle and sticks at all-ones.
module hazard_perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (en_i && (count_q != '1)) begin
            count_q <= count_q + CNT_ONE;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: memory wait > multi-cycle wait > mispredict > load-use.
// Controls are combinational from state and inputs; stall/flush cycles are counted.
module hazard_control_unit
    import pipeline_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic                  id_uses_rs1_i,
    input  logic                  id_uses_rs2_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic                  ex_mem_read_i,
    input  logic                  ex_mispredict_i,
    input  logic                  ex_mc_start_i,
    input  logic                  mc_done_i,
    input  logic                  mem_req_i,
    input  logic                  dmem_ready_i,
    output logic                  pc_stall_o,
    output logic                  if_id_stall_o,
    output logic                  if_id_flush_o,
    output logic                  id_ex_stall_o,
    output logic                  id_ex_flush_o,
    output logic                  ex_mem_stall_o,
    output logic                  ex_mem_flush_o,
    output logic [CNT_W-1:0]      stall_count_o,
    output logic [CNT_W-1:0]      flush_count_o
);

    localparam hcu_ctrl_t CTRL_MEM = '{pc_stall: 1'b1, if_id_stall: 1'b1, id_ex_stall: 1'b1,
                                       ex_mem_stall: 1'b1, default: 1'b0};
    localparam hcu_ctrl_t CTRL_MC  = '{pc_stall: 1'b1, if_id_stall: 1'b1, id_ex_stall: 1'b1,
                                       ex_mem_flush: 1'b1, default: 1'b0};
    localparam hcu_ctrl_t CTRL_MIS = '{if_id_flush: 1'b1, id_ex_flush: 1'b1, default: 1'b0};
    localparam hcu_ctrl_t CTRL_LU  = '{pc_stall: 1'b1, if_id_stall: 1'b1, id_ex_flush: 1'b1,
                                       default: 1'b0};

    hcu_state_e state_q, state_d;
    logic       mc_pend_q, mc_pend_d;
    hcu_ctrl_t  ctrl;
    logic       mem_block;
    logic       mc_active;
    logic       load_use;

    assign mem_block = mem_req_i && !dmem_ready_i;
    // A memory wait can interrupt a multi-cycle wait; mc_pend_q remembers to resume it.
    assign mc_active = (state_q == MC_WAIT) || ((state_q == MEM_WAIT) && mc_pend_q);
    assign load_use  = ex_mem_read_i && (ex_rd_i != '0) &&
                       ((id_uses_rs1_i && (id_rs1_i == ex_rd_i)) ||
                        (id_uses_rs2_i && (id_rs2_i == ex_rd_i)));

    always_comb begin
        ctrl      = '0;
        state_d   = state_q;
        mc_pend_d = mc_pend_q;
        if (mem_block) begin
            ctrl      = CTRL_MEM;
            state_d   = MEM_WAIT;
            mc_pend_d = mc_active;
        end else if (mc_active) begin
            mc_pend_d = 1'b0;
            if (!mc_done_i) begin
                ctrl    = CTRL_MC;
                state_d = MC_WAIT;
            end else begin
                state_d = RUN;
            end
        end else begin
            mc_pend_d = 1'b0;
            state_d   = RUN;
            if (ex_mc_start_i && !mc_done_i) begin
                ctrl    = CTRL_MC;
                state_d = MC_WAIT;
            end else if (ex_mispredict_i) begin
                ctrl = CTRL_MIS;
            end else if (load_use) begin
                ctrl = CTRL_LU;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= RUN;
            mc_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mc_pend_q <= mc_pend_d;
        end
    end

    // Outputs are forced low the instant reset asserts, not at the next edge.
    assign pc_stall_o     = reset_n && ctrl.pc_stall;
    assign if_id_stall_o  = reset_n && ctrl.if_id_stall;
    assign if_id_flush_o  = reset_n && ctrl.if_id_flush;
    assign id_ex_stall_o  = reset_n && ctrl.id_ex_stall;
    assign id_ex_flush_o  = reset_n && ctrl.id_ex_flush;
    assign ex_mem_stall_o = reset_n && ctrl.ex_mem_stall;
    assign ex_mem_flush_o = reset_n && ctrl.ex_mem_flush;

    hazard_perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .en_i    (pc_stall_o),
        .count_o (stall_count_o)
    );

    hazard_perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .en_i    (if_id_flush_o),
        .count_o (flush_count_o)
    );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed + random bench for hazard_control_unit; a 4-bit-counter copy shares the stimulus.
module tb_hazard_control_unit;

    localparam logic [6:0] E_NONE = 7'b0000000;
    localparam logic [6:0] E_MEM  = 7'b1101010;
    localparam logic [6:0] E_MC   = 7'b1101001;
    localparam logic [6:0] E_MIS  = 7'b0010100;
    localparam logic [6:0] E_LU   = 7'b1100100;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       uses1, uses2, mem_read, mispred, mc_start, mc_done, mem_req, dmem_ready;

    logic        a_pc, a_ifs, a_iff, a_ids, a_idf, a_ems, a_emf;
    logic        b_pc, b_ifs, b_iff, b_ids, b_idf, b_ems, b_emf;
    logic [31:0] a_stall_cnt, a_flush_cnt;
    logic [3:0]  b_stall_cnt, b_flush_cnt;
    logic [6:0]  a_ctrl, b_ctrl;

    assign a_ctrl = {a_pc, a_ifs, a_iff, a_ids, a_idf, a_ems, a_emf};
    assign b_ctrl = {b_pc, b_ifs, b_iff, b_ids, b_idf, b_ems, b_emf};

    int passed = 0;
    int total  = 0;

    bit     busy;
    longint exp_stall, exp_flush;

    always #5 clk = ~clk;

    hazard_control_unit dut_a (
        .clk(clk), .reset_n(reset_n),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_uses_rs1_i(uses1), .id_uses_rs2_i(uses2),
        .ex_rd_i(ex_rd), .ex_mem_read_i(mem_read), .ex_mispredict_i(mispred),
        .ex_mc_start_i(mc_start), .mc_done_i(mc_done), .mem_req_i(mem_req), .dmem_ready_i(dmem_ready),
        .pc_stall_o(a_pc), .if_id_stall_o(a_ifs), .if_id_flush_o(a_iff), .id_ex_stall_o(a_ids),
        .id_ex_flush_o(a_idf), .ex_mem_stall_o(a_ems), .ex_mem_flush_o(a_emf),
        .stall_count_o(a_stall_cnt), .flush_count_o(a_flush_cnt)
    );

    hazard_control_unit #(.REG_ADDR_W(5), .CNT_W(4)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_uses_rs1_i(uses1), .id_uses_rs2_i(uses2),
        .ex_rd_i(ex_rd), .ex_mem_read_i(mem_read), .ex_mispredict_i(mispred),
        .ex_mc_start_i(mc_start), .mc_done_i(mc_done), .mem_req_i(mem_req), .dmem_ready_i(dmem_ready),
        .pc_stall_o(b_pc), .if_id_stall_o(b_ifs), .if_id_flush_o(b_iff), .id_ex_stall_o(b_ids),
        .id_ex_flush_o(b_idf), .ex_mem_stall_o(b_ems), .ex_mem_flush_o(b_emf),
        .stall_count_o(b_stall_cnt), .flush_count_o(b_flush_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] sat4(input longint v);
        return (v > 15) ? 32'd15 : 32'(v);
    endfunction

    // Reference: "busy" means a multi-cycle op is outstanding; memory waits freeze everything.
    function automatic void model(output logic [6:0] e, output bit nb);
        e  = E_NONE;
        nb = busy;
        if (!reset_n) begin
            nb = 1'b0;
        end else if (mem_req && !dmem_ready) begin
            e = E_MEM;
        end else if (busy) begin
            if (mc_done) nb = 1'b0;
            else         e  = E_MC;
        end else if (mc_start && !mc_done) begin
            e  = E_MC;
            nb = 1'b1;
        end else if (mispred) begin
            e = E_MIS;
        end else if (mem_read && ex_rd != 5'd0 &&
                     ((uses1 && id_rs1 == ex_rd) || (uses2 && id_rs2 == ex_rd))) begin
            e = E_LU;
        end
    endfunction

    task automatic idle();
        id_rs1 = 0; id_rs2 = 0; ex_rd = 0; uses1 = 0; uses2 = 0; mem_read = 0;
        mispred = 0; mc_start = 0; mc_done = 0; mem_req = 0; dmem_ready = 1;
    endtask

    // Called at a falling edge with inputs applied; checks just before the rising edge.
    task automatic cycle(input string tag);
        logic [6:0] e;
        bit         nb;
        #4;
        model(e, nb);
        chk({tag, ".ctrl"},  {25'd0, a_ctrl}, {25'd0, e});
        chk({tag, ".ctrlb"}, {25'd0, b_ctrl}, {25'd0, e});
        chk({tag, ".inv"}, {29'd0, a_ifs & a_iff, a_ids & a_idf, a_ems & a_emf}, 32'd0);
        chk({tag, ".scnt"},  a_stall_cnt, 32'(exp_stall));
        chk({tag, ".fcnt"},  a_flush_cnt, 32'(exp_flush));
        chk({tag, ".scntb"}, {28'd0, b_stall_cnt}, sat4(exp_stall));
        chk({tag, ".fcntb"}, {28'd0, b_flush_cnt}, sat4(exp_flush));
        @(posedge clk);
        if (reset_n) begin
            busy = nb;
            if (e[6]) exp_stall++;
            if (e[4]) exp_flush++;
        end
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0;
        idle();
        busy = 0; exp_stall = 0; exp_flush = 0;
        #2;
        chk("rst.ctrl", {25'd0, a_ctrl}, 32'd0);
        chk("rst.scnt", a_stall_cnt, 32'd0);
        chk("rst.fcnt", a_flush_cnt, 32'd0);
        mispred = 1; mem_req = 1; dmem_ready = 0;
        #1;
        chk("rst.gated", {25'd0, a_ctrl}, 32'd0);
        idle();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Load-use on rs2
        mem_read = 1; ex_rd = 5; id_rs2 = 5; uses2 = 1;
        cycle("lu");
        idle();
        cycle("lu_after");
        chk("lu.stall_count", a_stall_cnt, 32'd1);

        // rd = x0 never hazards; mispredict suppresses load-use
        mem_read = 1; ex_rd = 0; id_rs2 = 0; uses2 = 1;
        cycle("lu_x0");
        ex_rd = 5; id_rs2 = 5; mispred = 1;
        cycle("mis_lu");
        idle();
        cycle("mis_after");
        chk("mis.flush_count", a_flush_cnt, 32'd1);

        // Multi-cycle op, done in the 4th cycle
        mc_start = 1;
        for (int i = 0; i < 3; i++) cycle("mc_wait");
        mc_done = 1;
        cycle("mc_done");
        idle();
        cycle("mc_after");
        chk("mc.stall_count", a_stall_cnt, 32'd4);

        // Memory wait on top of MC_WAIT with a mispredict pending
        mc_start = 1;
        cycle("mc2_start");
        mem_req = 1; dmem_ready = 0; mispred = 1;
        cycle("mem_in_mc0");
        cycle("mem_in_mc1");
        dmem_ready = 1;
        cycle("mc_resume");
        mem_req = 0;
        cycle("mc_resume2");
        mc_done = 1;
        cycle("mc2_done");
        idle();
        cycle("mc2_after");

        // Reset abandons a MEM_WAIT entered from MC_WAIT
        mc_start = 1;
        cycle("mc3_start");
        mem_req = 1; dmem_ready = 0;
        cycle("mem3");
        reset_n = 1'b0;
        #1;
        chk("rst_mid.ctrl",  {25'd0, a_ctrl}, 32'd0);
        chk("rst_mid.ctrlb", {25'd0, b_ctrl}, 32'd0);
        chk("rst_mid.scnt",  a_stall_cnt, 32'd0);
        chk("rst_mid.fcnt",  a_flush_cnt, 32'd0);
        busy = 0; exp_stall = 0; exp_flush = 0;
        @(negedge clk);
        reset_n = 1'b1;
        idle();
        cycle("post_rst_run");

        // 20 stall cycles saturate the 4-bit counter
        mem_req = 1; dmem_ready = 0;
        for (int i = 0; i < 20; i++) cycle("sat");
        idle();
        cycle("sat_after");
        chk("sat.a", a_stall_cnt, 32'd20);
        chk("sat.b", {28'd0, b_stall_cnt}, 32'd15);

        // Random traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            mem_req    = ($urandom_range(0, 3) == 0);
            dmem_ready = $urandom_range(0, 1) == 1;
            mc_start   = ($urandom_range(0, 4) == 0);
            mc_done    = ($urandom_range(0, 2) == 0);
            mispred    = ($urandom_range(0, 3) == 0);
            mem_read   = $urandom_range(0, 1) == 1;
            uses1      = $urandom_range(0, 1) == 1;
            uses2      = $urandom_range(0, 1) == 1;
            id_rs1     = 5'($urandom_range(0, 3));
            id_rs2     = 5'($urandom_range(0, 3));
            ex_rd      = 5'($urandom_range(0, 3));
            cycle("rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
